paddle_btn_ctrl: RTL and testbench

//   Front end for the paddle: turns two raw pushbuttons (up/down) into the 2-bit move code the paddle consumes.

---
 rtl/paddle_btn_ctrl.sv | 165 ++++++++++++++++
 tb/tb_paddle_btn_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/paddle_btn_ctrl.sv
// paddle_btn_ctrl: turns the raw up/down pushbuttons into the paddle's 2-bit move code.
// Processing order: two-flop synchroniser, then a per-button debouncer, then an encoder FSM.
// The FSM emits a registered one-cycle pulse: 2'b01 for up, 2'b10 for down.
// Pressing both buttons parks the FSM in BOTH, which raises conflict and emits nothing.
// Optional hold-to-repeat is built only when the macro PADDLE_BTN_REPEAT_EN is defined.
// Without that macro, each debounced press produces exactly one pulse.
module paddle_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int INITIAL_DELAY   = 32,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  output logic [1:0] btn,
  output logic       conflict
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Catch out-of-range parameters at elaboration rather than in silicon.
  if (DEBOUNCE_CYCLES < 1 || INITIAL_DELAY < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("paddle_btn_ctrl: DEBOUNCE_CYCLES>=1, INITIAL_DELAY>=2, REPEAT_CYCLES>=2 required");
  end

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_BOTH} state_t;

  // Bit 0 carries the up button and bit 1 carries the down button.
  logic [1:0]      sync1, sync2, deb;
  logic [DB_W-1:0] db_cnt [2];
  logic            deb_up, deb_dn;
  state_t          state, state_nxt;
  logic [1:0]      btn_nxt;
  logic            rpt_fire;

  // Two-flop synchroniser for the asynchronous pushbuttons.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking. As a result, sync2 takes the old sync1
    // and does not take the value loaded on this same edge.
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_down_raw, btn_up_raw};
      sync2 <= sync1;
    end
  end

  // Debounce: a level change must hold for DEBOUNCE_CYCLES cycles before deb follows it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign deb_up = deb[0];
  assign deb_dn = deb[1];

`ifdef PADDLE_BTN_REPEAT_EN
  localparam int RPT_MAX = (INITIAL_DELAY > REPEAT_CYCLES) ? INITIAL_DELAY : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;  // still waiting out the longer initial delay

  // A repeat pulse is due once the current interval has fully elapsed.
  always_comb begin
    if (rpt_first) rpt_fire = (rpt_cnt == RPT_W'(INITIAL_DELAY - 1));
    else           rpt_fire = (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));
  end

  // Repeat timer: restarts on every state change and after each repeat pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state_nxt != state) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state == S_UP || state == S_DOWN) begin
      if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end else begin
      rpt_cnt <= '0;
    end
  end
`else
  // Without hold-to-repeat, no pulse is ever due after the entry pulse.
  assign rpt_fire = 1'b0;
`endif

  // State register and registered move code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      btn   <= 2'b00;
    end else begin
      state <= state_nxt;
      btn   <= btn_nxt;
    end
  end

  // Next-state logic. BOTH exits only to IDLE, so a staggered release cannot cause a move.
  always_comb begin
    // NOTE: state_nxt gets a default before the case. Without it, any path that leaves it
    // unassigned would infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (deb_up && deb_dn)  state_nxt = S_BOTH;
        else if (deb_up)       state_nxt = S_UP;
        else if (deb_dn)       state_nxt = S_DOWN;
      end
      S_UP: begin
        if (deb_dn)            state_nxt = S_BOTH;
        else if (!deb_up)      state_nxt = S_IDLE;
      end
      S_DOWN: begin
        if (deb_up)            state_nxt = S_BOTH;
        else if (!deb_dn)      state_nxt = S_IDLE;
      end
      S_BOTH: begin
        if (!deb_up && !deb_dn) state_nxt = S_IDLE;
      end
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Output logic: entry pulse on IDLE->UP/DOWN, then repeat pulses while staying put.
  always_comb begin
    btn_nxt  = 2'b00;
    conflict = (state == S_BOTH);
    case (state)
      S_IDLE: begin
        if (state_nxt == S_UP)        btn_nxt = 2'b01;
        else if (state_nxt == S_DOWN) btn_nxt = 2'b10;
      end
      S_UP:   if (state_nxt == S_UP && rpt_fire)   btn_nxt = 2'b01;
      S_DOWN: if (state_nxt == S_DOWN && rpt_fire) btn_nxt = 2'b10;
      default: btn_nxt = 2'b00;
    endcase
  end

  a_btn_never_11: assert property (@(posedge clk) btn != 2'b11)
    else $error("paddle_btn_ctrl: btn reached 2'b11");

endmodule

// File: tb/tb_paddle_btn_ctrl.sv
// Testbench for paddle_btn_ctrl. Parameters are DEBOUNCE_CYCLES=4, INITIAL_DELAY=8, REPEAT_CYCLES=4.
// Each driven cycle pushes the expected {btn, conflict} for the following posedge onto a queue.
// A monitor pops that entry 2 time units after the edge and compares it.
// With these parameters, a clean raw rise driven before posedge r becomes debounced at posedge
// r+5, and the move pulse appears at posedge r+6. Counting the rise edge as 1, that is
// posedge 7 after the rise.
module tb_paddle_btn_ctrl;
  localparam int DEB  = 4;
  localparam int INIT = 8;
  localparam int RPT  = 4;

  logic       clk = 1'b0;
  logic       rst_n, up, dn;
  logic [1:0] btn;
  logic       conflict;

  paddle_btn_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .INITIAL_DELAY  (INIT),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up_raw  (up),
    .btn_down_raw(dn),
    .btn         (btn),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;
    logic       conf;
    string      name;
  } exp_t;

  typedef struct {
    string      name;
    logic       r, u, d;
    int         len;
    logic [1:0] eb;
    logic       ec;
  } seg_t;

  exp_t exp_q[$];
  seg_t vec[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got btn=%b conflict=%b, want btn=%b conflict=%b",
                  name, act[2:1], act[0], req[2:1], req[0]);
  endtask

  // Monitor: compare the output settled after each posedge with the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.name, {btn, conflict}, {mon_e.btn, mon_e.conf});
    end
  end

  // Drive one cycle of inputs at the falling edge and queue what the next posedge must give.
  task automatic drive(input logic r, input logic u, input logic d,
                       input logic [1:0] eb, input logic ec, input string name);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    up    = u;
    dn    = d;
    e.btn  = eb;
    e.conf = ec;
    e.name = name;
    exp_q.push_back(e);
  endtask

  function automatic void add(input string n, input logic r, input logic u, input logic d,
                              input int len, input logic [1:0] eb, input logic ec);
    seg_t s;
    s.name = n; s.r = r; s.u = u; s.d = d; s.len = len; s.eb = eb; s.ec = ec;
    vec.push_back(s);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    up    = 1'b0;
    dn    = 1'b0;

    // Reset with both raw buttons high, then come out of reset idle.
    add("t1_rst",  0, 1, 1, 3, 2'b00, 0);
    add("t1_idle", 1, 0, 0, 4, 2'b00, 0);

`ifdef PADDLE_BTN_REPEAT_EN
    // Hold up for 40 cycles. Pulses land at edges 7, 15, then every 4 edges.
    // They continue until the debounced level falls at edge 46, so edge 43 still pulses.
    add("t2_hold", 1, 1, 0, 6, 2'b00, 0);
    add("t2_p7",   1, 1, 0, 1, 2'b01, 0);
    add("t2_hold", 1, 1, 0, 7, 2'b00, 0);
    add("t2_p15",  1, 1, 0, 1, 2'b01, 0);
    for (int k = 0; k < 6; k++) begin
      add("t2_gap", 1, 1, 0, 3, 2'b00, 0);
      add("t2_rep", 1, 1, 0, 1, 2'b01, 0);
    end
    add("t2_hold",  1, 1, 0, 1, 2'b00, 0);
    add("t2_rel",   1, 0, 0, 2, 2'b00, 0);
    add("t2_p43",   1, 0, 0, 1, 2'b01, 0);
    add("t2_quiet", 1, 0, 0, 9, 2'b00, 0);
`else
    // Without repeat: a 50-cycle hold gives one 01 pulse, then a down press gives one 10 pulse.
    add("t6_up",    1, 1, 0,  6, 2'b00, 0);
    add("t6_p_up",  1, 1, 0,  1, 2'b01, 0);
    add("t6_up",    1, 1, 0, 43, 2'b00, 0);
    add("t6_rel",   1, 0, 0, 10, 2'b00, 0);
    add("t6_dn",    1, 0, 1,  6, 2'b00, 0);
    add("t6_p_dn",  1, 0, 1,  1, 2'b10, 0);
    add("t6_dn",    1, 0, 1, 13, 2'b00, 0);
    add("t6_rel",   1, 0, 0, 10, 2'b00, 0);
`endif

    // Hold down until its pulse, then add up. BOTH starts at edge 14 and blocks the repeat.
    // Releasing up alone keeps BOTH. Releasing down returns the FSM to IDLE at edge 37.
    // A fresh down press then gives one 10 pulse 7 edges later.
    add("t4_dn",       1, 0, 1,  6, 2'b00, 0);
    add("t4_p_dn",     1, 0, 1,  1, 2'b10, 0);
    add("t4_both_deb", 1, 1, 1,  6, 2'b00, 0);
    add("t4_both",     1, 1, 1,  7, 2'b00, 1);
    add("t4_up_rel",   1, 0, 1, 10, 2'b00, 1);
    add("t4_dn_rel",   1, 0, 0,  6, 2'b00, 1);
    add("t4_idle",     1, 0, 0,  4, 2'b00, 0);
    add("t4_dn2",      1, 0, 1,  6, 2'b00, 0);
    add("t4_p_dn2",    1, 0, 1,  1, 2'b10, 0);
    add("t4_dn2",      1, 0, 1,  1, 2'b00, 0);
    add("t4_quiet",    1, 0, 0, 12, 2'b00, 0);

    for (int i = 0; i < vec.size(); i++)
      for (int k = 0; k < vec[i].len; k++)
        drive(vec[i].r, vec[i].u, vec[i].d, vec[i].eb, vec[i].ec,
              $sformatf("%s[%0d]", vec[i].name, k));

    // Bounce: up toggles every 2 cycles for 20 cycles and never stays stable long enough.
    for (int k = 0; k < 20; k++) drive(1, ((k / 2) % 2) == 0, 0, 2'b00, 0, "t3_bounce");
    for (int k = 0; k < 8; k++)  drive(1, 0, 0, 2'b00, 0, "t3_quiet");

    // Reset mid-hold at edge 12. The debouncer restarts from zero.
    // The next pulse therefore lands 7 edges after reset is released (edge 19).
    for (int k = 1; k <= 6; k++)  drive(1, 1, 0, 2'b00, 0, "t5_hold");
    drive(1, 1, 0, 2'b01, 0, "t5_p7");
    for (int k = 8; k <= 11; k++) drive(1, 1, 0, 2'b00, 0, "t5_hold");
    drive(0, 1, 0, 2'b00, 0, "t5_rst");
    for (int k = 13; k <= 18; k++) drive(1, 1, 0, 2'b00, 0, "t5_rehold");
    drive(1, 1, 0, 2'b01, 0, "t5_p19");
    drive(1, 1, 0, 2'b00, 0, "t5_hold");
    for (int k = 21; k <= 30; k++) drive(1, 0, 0, 2'b00, 0, "t5_rel");

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
